sram_serial_host: RTL and testbench
===================================

Name: sram_serial_host

Overview:
- Host-side serial master for the SRAM load/dump port of the SCPU chip; the other end of the CTRL_BGN/LOAD_N/CTRL_MODE/CTRL_SI/CTRL_SO/CTRL_RDY link.
- Accepts word-level read/write requests over a valid/ready handshake.
- Serializes the address/data frame onto the link, waits for the target's ready strobe, and for reads deserializes the returned byte.
- Sits in the tester/FPGA wrapper that preloads instruction memory and dumps results after a CPU run.

Parameters:
- ADDR_WIDTH, 9, SRAM address bits
- DATA_WIDTH, 8, SRAM word bits
- FRAME_WIDTH, ADDR_WIDTH+DATA_WIDTH, serial frame length in bits
- RDY_TIMEOUT, 64, maximum CLK cycles to wait for CTRL_RDY before flagging an error

Ports:
- CLK input 1 system clock, rising edge
- RST input 1 asynchronous reset, active high
- REQ_VALID input 1 request present
- REQ_READY output 1 block can accept a request
- REQ_WE input 1 1=write, 0=read
- REQ_ADDR input ADDR_WIDTH target SRAM address
- REQ_WDATA input DATA_WIDTH write data (ignored for reads)
- RSP_VALID output 1 one-cycle completion pulse
- RSP_RDATA output DATA_WIDTH read data, valid with RSP_VALID on a read
- RSP_ERR output 1 timeout flag, valid with RSP_VALID
- CTRL_BGN output 1 link session active
- CTRL_MODE output 2 01=write, 10=read, 00=idle
- LOAD_N output 1 shift-enable, active low
- CTRL_SI output 1 serial data to target
- CTRL_SO input 1 serial data from target
- CTRL_RDY input 1 target access-complete strobe

Behaviour:
- One clock and one reset: asynchronous, active-high reset RST; all state is clocked on the CLK rising edge.
- Reset values:
  - REQ_READY=0 while RST is asserted, then 1 in IDLE.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0.
  - CTRL_BGN=0, CTRL_MODE=00, LOAD_N=1, CTRL_SI=0.
  - State=IDLE, all counters=0.
- Handshake:
  - A request is accepted when REQ_VALID and REQ_READY are both high on an edge.
  - REQ_READY is high only in IDLE.
  - Address, data and WE are captured into internal registers at acceptance.
  - The requester may change inputs after acceptance.
- FSM states: IDLE, SHIFT_OUT, WAIT_RDY, SHIFT_IN, RESP.
- IDLE -> SHIFT_OUT on acceptance:
  - Load shift register = {addr, wdata}; a read loads wdata as 0.
  - CTRL_BGN=1; CTRL_MODE=01 for a write, 10 for a read.
- SHIFT_OUT:
  - LOAD_N=0 for exactly FRAME_WIDTH cycles.
  - CTRL_SI carries the frame MSB first; the address MSB is in the first cycle, the data LSB in the last.
  - Bit counter counts 0..FRAME_WIDTH-1. At terminal count -> WAIT_RDY with LOAD_N=1.
- WAIT_RDY:
  - LOAD_N=1; the timeout counter increments each cycle.
  - CTRL_RDY=1 on a write -> RESP with ERR=0.
  - CTRL_RDY=1 on a read -> SHIFT_IN.
  - Counter reaching RDY_TIMEOUT-1 with no RDY -> RESP with ERR=1, RDATA=0.
  - If RDY and timeout occur in the same cycle, RDY wins.
- SHIFT_IN (reads only):
  - LOAD_N=0 for DATA_WIDTH cycles.
  - CTRL_SO is sampled each edge and shifted in MSB first.
  - After the DATA_WIDTH-th sample -> RESP.
- RESP:
  - RSP_VALID=1 for exactly one cycle with RDATA and ERR.
  - CTRL_BGN=0, CTRL_MODE=00.
  - Next state is IDLE; REQ_READY rises the cycle after RSP_VALID.
- CTRL_RDY outside WAIT_RDY is ignored.
- CTRL_SO outside SHIFT_IN is ignored.
- Minimum latency from acceptance to RSP_VALID:
  - Write: FRAME_WIDTH+2 cycles, with RDY on the first WAIT_RDY cycle (19 at defaults).
  - Read: FRAME_WIDTH+DATA_WIDTH+2 cycles (27 at defaults).
- RST mid-transaction:
  - Immediate return to reset values; the in-flight request is dropped with no RSP_VALID.
  - LOAD_N goes high and CTRL_BGN low asynchronously.
- All link outputs are registered; no combinational path from CTRL_SO or CTRL_RDY to any output.

Decomposition:
- Shared package (DEFINE_CPU-style include):
  - CTRL_MODE encodings MODE_IDLE, MODE_WRITE, MODE_READ.
  - State encodings.
  - Default ADDR_WIDTH and DATA_WIDTH.
- One sub-module, serial_shift_reg: a parameterised width with parallel load, MSB-first shift-out and shift-in. Instantiated once at FRAME_WIDTH for SHIFT_OUT; the SHIFT_IN path reuses it or a second DATA_WIDTH instance.

Test Plan:
- Write addr=0x010, data=0xA5, RDY on the first WAIT_RDY cycle -> SI sequence 0_0001_0000_1010_0101 over 17 LOAD_N-low cycles, MODE=01, RSP_VALID with ERR=0 at cycle 19.
- Read addr=0x1FF, RDY after 3 wait cycles, target drives SO=0x3C MSB first -> frame 1_1111_1111_0000_0000, MODE=10, RSP_RDATA=0x3C, ERR=0.
- Write with RDY never asserted -> after 64 WAIT_RDY cycles, RSP_VALID with ERR=1, BGN drops, REQ_READY returns.
- Back-to-back: REQ_VALID held with two writes -> second accepted the cycle after the first RSP_VALID, no overlap of LOAD_N-low windows, spurious RDY during SHIFT_OUT ignored.
- Assert RST at frame bit 8 of a read -> LOAD_N=1, BGN=0, MODE=00 immediately; no RSP_VALID; next request completes normally.
- RDY and timeout in the same cycle (RDY on wait cycle 64) -> ERR=0, completion treated as success.

Source files
------------

// File: rtl/sram_serial_host_pkg.sv
// Shared definitions for the SRAM serial load/dump host: link mode codes,
// FSM state encoding and default geometry of the SCPU SRAM port.
package sram_serial_host_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 9;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_READ  = 2'b10
    } ctrl_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_OUT,
        ST_WAIT_RDY,
        ST_SHIFT_IN,
        ST_RESP
    } state_e;

endpackage

// File: rtl/sram_serial_host_if.sv
// Word-level request/response channel between a requester and the SRAM
// serial host.
interface sram_serial_host_if #(
    parameter int ADDR_WIDTH = sram_serial_host_pkg::DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_serial_host_pkg::DEFAULT_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_serial_host_serial_shift_reg.sv
// Parallel-load shift register, MSB-first out, new bits enter at the LSB.
// Exposes the serial MSB and the low PAR_WIDTH bits as a parallel word.
module serial_shift_reg #(
    parameter int WIDTH     = 17,
    parameter int PAR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 shift_en,
    input  logic                 din,
    output logic                 sout,
    output logic [PAR_WIDTH-1:0] q_lo
);
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] shifted;

    assign shifted[0] = din;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
        assign shifted[gi] = q_reg[gi-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_val;
        end else if (shift_en) begin
            q_reg <= shifted;
        end
    end

    assign sout = q_reg[WIDTH-1];
    assign q_lo = q_reg[PAR_WIDTH-1:0];
endmodule

// File: rtl/sram_serial_host.sv
// Host-side serial master for the SCPU SRAM load/dump link: serializes
// {addr, data} frames, waits for the target strobe, deserializes read bytes.
module sram_serial_host
    import sram_serial_host_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH,
    parameter int RDY_TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_serial_host_if.slave       host,
    output logic                    ctrl_bgn,
    output logic [1:0]              ctrl_mode,
    output logic                    load_n,
    output logic                    ctrl_si,
    input  logic                    ctrl_so,
    input  logic                    ctrl_rdy
);
    localparam int CNT_MAX   = (FRAME_WIDTH > RDY_TIMEOUT) ? FRAME_WIDTH : RDY_TIMEOUT;
    localparam int CNT_WIDTH = $clog2(CNT_MAX);

    state_e                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic                   we_reg, we_next;
    logic                   req_ready_reg, req_ready_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic                   rsp_err_reg, rsp_err_next;
    logic                   ctrl_bgn_reg, ctrl_bgn_next;
    ctrl_mode_e             ctrl_mode_reg, ctrl_mode_next;
    logic                   load_n_reg, load_n_next;

    logic                   sr_load, sr_shift, sr_din;
    logic [FRAME_WIDTH-1:0] frame_load;
    logic [DATA_WIDTH-1:0]  sr_lo;

    // Reads carry a zero data field so the target sees a fixed-length frame.
    assign frame_load = {host.req_addr, host.req_we ? host.req_wdata : DATA_WIDTH'(0)};

    // One register serves both directions: after the frame is fully shifted
    // out it holds zeros, so its MSB doubles as an idle-low CTRL_SI and its
    // low byte collects the returned read data (or stays 0 on write/timeout).
    serial_shift_reg #(
        .WIDTH     (FRAME_WIDTH),
        .PAR_WIDTH (DATA_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (sr_load),
        .load_val (frame_load),
        .shift_en (sr_shift),
        .din      (sr_din),
        .sout     (ctrl_si),
        .q_lo     (sr_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            ctrl_bgn_reg  <= 1'b0;
            ctrl_mode_reg <= MODE_IDLE;
            load_n_reg    <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            we_reg        <= we_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            ctrl_bgn_reg  <= ctrl_bgn_next;
            ctrl_mode_reg <= ctrl_mode_next;
            load_n_reg    <= load_n_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        we_next        = we_reg;
        rsp_valid_next = 1'b0;
        rsp_err_next   = rsp_err_reg;
        ctrl_bgn_next  = ctrl_bgn_reg;
        ctrl_mode_next = ctrl_mode_reg;
        load_n_next    = 1'b1;
        sr_load        = 1'b0;
        sr_shift       = 1'b0;
        sr_din         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (host.req_valid && req_ready_reg) begin
                    state_next     = ST_SHIFT_OUT;
                    cnt_next       = '0;
                    we_next        = host.req_we;
                    rsp_err_next   = 1'b0;
                    sr_load        = 1'b1;
                    ctrl_bgn_next  = 1'b1;
                    ctrl_mode_next = host.req_we ? MODE_WRITE : MODE_READ;
                    load_n_next    = 1'b0;
                end
            end
            ST_SHIFT_OUT: begin
                sr_shift = 1'b1;
                if (cnt_reg == CNT_WIDTH'(FRAME_WIDTH - 1)) begin
                    state_next = ST_WAIT_RDY;
                    cnt_next   = '0;
                end else begin
                    cnt_next    = cnt_reg + 1'b1;
                    load_n_next = 1'b0;
                end
            end
            ST_WAIT_RDY: begin
                // RDY is tested first so a strobe on the last allowed cycle still succeeds.
                if (ctrl_rdy) begin
                    cnt_next = '0;
                    if (we_reg) begin
                        state_next     = ST_RESP;
                        rsp_valid_next = 1'b1;
                        ctrl_bgn_next  = 1'b0;
                        ctrl_mode_next = MODE_IDLE;
                    end else begin
                        state_next  = ST_SHIFT_IN;
                        load_n_next = 1'b0;
                    end
                end else if (cnt_reg == CNT_WIDTH'(RDY_TIMEOUT - 1)) begin
                    state_next     = ST_RESP;
                    cnt_next       = '0;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                    ctrl_bgn_next  = 1'b0;
                    ctrl_mode_next = MODE_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_SHIFT_IN: begin
                sr_shift = 1'b1;
                sr_din   = ctrl_so;
                if (cnt_reg == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                    state_next     = ST_RESP;
                    cnt_next       = '0;
                    rsp_valid_next = 1'b1;
                    ctrl_bgn_next  = 1'b0;
                    ctrl_mode_next = MODE_IDLE;
                end else begin
                    cnt_next    = cnt_reg + 1'b1;
                    load_n_next = 1'b0;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        req_ready_next = (state_next == ST_IDLE);
    end

    assign host.req_ready = req_ready_reg;
    assign host.rsp_valid = rsp_valid_reg;
    assign host.rsp_rdata = sr_lo;
    assign host.rsp_err   = rsp_err_reg;
    assign ctrl_bgn       = ctrl_bgn_reg;
    assign ctrl_mode      = ctrl_mode_reg;
    assign load_n         = load_n_reg;
endmodule

// File: tb/tb_sram_serial_host.sv
// Directed bench for sram_serial_host: acts as requester and as the SRAM-side
// link target, checking frames, timing, read data, timeout and reset.
module tb_sram_serial_host;
    localparam int FW = 17;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ctrl_bgn;
    logic [1:0] ctrl_mode;
    logic       load_n;
    logic       ctrl_si;
    logic       ctrl_so = 1'b0;
    logic       ctrl_rdy = 1'b0;

    int tests = 0;
    int fails = 0;

    sram_serial_host_if rq ();

    sram_serial_host dut (
        .clk       (clk),
        .rst       (rst),
        .host      (rq),
        .ctrl_bgn  (ctrl_bgn),
        .ctrl_mode (ctrl_mode),
        .load_n    (load_n),
        .ctrl_si   (ctrl_si),
        .ctrl_so   (ctrl_so),
        .ctrl_rdy  (ctrl_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic issue(input logic we, input logic [8:0] a, input logic [7:0] d);
        int n;
        n = 0;
        rq.req_valid = 1'b1; rq.req_we = we; rq.req_addr = a; rq.req_wdata = d;
        while (rq.req_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", rq.req_ready, 1);
        chk("load_n_idle", load_n, 1);
        @(negedge clk);
        rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;
    endtask

    // Samples CTRL_SI for FW cycles; returns at the negedge of the first wait cycle.
    task automatic grab_frame(input logic spur, output logic [16:0] fr);
        int low;
        low = 0;
        fr  = '0;
        for (int k = 0; k < FW; k++) begin
            fr = {fr[15:0], ctrl_si};
            if (load_n == 1'b0 && ctrl_bgn == 1'b1) low++;
            ctrl_rdy = spur;
            @(negedge clk);
        end
        ctrl_rdy = 1'b0;
        chk("load_low_cycles", low, FW);
        chk("load_n_after_frame", load_n, 1);
    endtask

    task automatic drive_so(input logic [7:0] v);
        for (int b = 7; b >= 0; b--) begin
            ctrl_so = v[b];
            @(negedge clk);
        end
        ctrl_so = 1'b0;
    endtask

    initial begin
        logic [16:0] fr;
        int seen;
        rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_addr = '0; rq.req_wdata = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_ready", rq.req_ready, 0);
        chk("rst_load_n", load_n, 1);
        chk("rst_bgn", ctrl_bgn, 0);
        chk("rst_mode", ctrl_mode, 2'b00);
        chk("rst_si", ctrl_si, 0);
        chk("rst_rsp_valid", rq.rsp_valid, 0);
        chk("rst_rdata", rq.rsp_rdata, 8'h00);
        chk("rst_err", rq.rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", rq.req_ready, 1);

        // Write 0x010 <- 0xA5, RDY on first wait cycle, RSP_VALID in cycle 19
        issue(1'b1, 9'h010, 8'hA5);
        chk("wr_mode", ctrl_mode, 2'b01);
        chk("wr_bgn", ctrl_bgn, 1);
        chk("wr_req_ready_busy", rq.req_ready, 0);
        grab_frame(1'b0, fr);
        chk("wr_frame", fr, 17'h010A5);
        chk("wr_no_early_rsp", rq.rsp_valid, 0);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        $display("[TB] write 010<-A5 frame=%05h rsp_valid=%0b err=%0b", fr, rq.rsp_valid, rq.rsp_err);
        chk("wr_rsp_valid_c19", rq.rsp_valid, 1);
        chk("wr_err", rq.rsp_err, 0);
        chk("wr_resp_bgn", ctrl_bgn, 0);
        chk("wr_resp_mode", ctrl_mode, 2'b00);
        chk("wr_resp_ready", rq.req_ready, 0);
        @(negedge clk);
        chk("wr_rsp_one_cycle", rq.rsp_valid, 0);
        chk("wr_ready_back", rq.req_ready, 1);

        // Read 0x1FF, three idle wait cycles, target returns 0x3C
        issue(1'b0, 9'h1FF, 8'hEE);
        chk("rd_mode", ctrl_mode, 2'b10);
        grab_frame(1'b0, fr);
        chk("rd_frame", fr, 17'h1FF00);
        ctrl_so = 1'b1;
        repeat (3) @(negedge clk);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        chk("rd_shift_in_load_n", load_n, 0);
        drive_so(8'h3C);
        $display("[TB] read 1FF frame=%05h rsp_valid=%0b rdata=%02h err=%0b", fr, rq.rsp_valid, rq.rsp_rdata, rq.rsp_err);
        chk("rd_rsp_valid", rq.rsp_valid, 1);
        chk("rd_rdata", rq.rsp_rdata, 8'h3C);
        chk("rd_err", rq.rsp_err, 0);
        chk("rd_resp_load_n", load_n, 1);
        @(negedge clk);

        // Write with no RDY: 64 wait cycles then error response
        issue(1'b1, 9'h055, 8'h3C);
        grab_frame(1'b0, fr);
        seen = 0;
        repeat (63) begin
            if (rq.rsp_valid) seen++;
            @(negedge clk);
        end
        chk("to_no_early_rsp", seen, 0);
        chk("to_last_wait_rsp", rq.rsp_valid, 0);
        @(negedge clk);
        $display("[TB] timeout write 055 rsp_valid=%0b err=%0b rdata=%02h", rq.rsp_valid, rq.rsp_err, rq.rsp_rdata);
        chk("to_rsp_valid", rq.rsp_valid, 1);
        chk("to_err", rq.rsp_err, 1);
        chk("to_rdata", rq.rsp_rdata, 8'h00);
        chk("to_bgn", ctrl_bgn, 0);
        @(negedge clk);
        chk("to_ready_back", rq.req_ready, 1);

        // RDY on wait cycle 64 coincides with timeout: RDY wins
        issue(1'b1, 9'h0C3, 8'h5A);
        grab_frame(1'b0, fr);
        repeat (63) @(negedge clk);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        $display("[TB] rdy+timeout write 0C3 rsp_valid=%0b err=%0b", rq.rsp_valid, rq.rsp_err);
        chk("tie_rsp_valid", rq.rsp_valid, 1);
        chk("tie_err", rq.rsp_err, 0);
        @(negedge clk);

        // Back-to-back writes with REQ_VALID held and spurious RDY while shifting
        rq.req_valid = 1'b1; rq.req_we = 1'b1; rq.req_addr = 9'h0AA; rq.req_wdata = 8'h11;
        seen = 0;
        while (rq.req_ready !== 1'b1 && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        chk("b2b_first_ready", rq.req_ready, 1);
        @(negedge clk);
        rq.req_addr = 9'h155; rq.req_wdata = 8'h22;
        grab_frame(1'b1, fr);
        chk("b2b_frame1", fr, 17'h0AA11);
        chk("b2b_spur_ignored", rq.rsp_valid, 0);
        @(negedge clk);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        chk("b2b_rsp1", rq.rsp_valid, 1);
        chk("b2b_ready_in_resp", rq.req_ready, 0);
        @(negedge clk);
        chk("b2b_ready_after_rsp", rq.req_ready, 1);
        chk("b2b_gap_load_n", load_n, 1);
        @(negedge clk);
        rq.req_valid = 1'b0;
        chk("b2b_second_started", ctrl_bgn, 1);
        chk("b2b_second_busy", rq.req_ready, 0);
        grab_frame(1'b0, fr);
        chk("b2b_frame2", fr, 17'h15522);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        $display("[TB] back-to-back second frame=%05h rsp_valid=%0b err=%0b", fr, rq.rsp_valid, rq.rsp_err);
        chk("b2b_rsp2", rq.rsp_valid, 1);
        chk("b2b_err2", rq.rsp_err, 0);
        @(negedge clk);

        // Reset at frame bit 8 of a read, then a normal read completes
        issue(1'b0, 9'h0F0, 8'h00);
        repeat (8) @(negedge clk);
        chk("mid_load_n_low", load_n, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_load_n", load_n, 1);
        chk("mid_rst_bgn", ctrl_bgn, 0);
        chk("mid_rst_mode", ctrl_mode, 2'b00);
        chk("mid_rst_ready", rq.req_ready, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rq.rsp_valid) seen++;
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rq.rsp_valid) seen++;
        end
        $display("[TB] reset mid-read: rsp_valid pulses seen=%0d", seen);
        chk("mid_no_rsp", seen, 0);
        chk("mid_ready_back", rq.req_ready, 1);
        issue(1'b0, 9'h123, 8'h00);
        grab_frame(1'b0, fr);
        chk("post_frame", fr, 17'h12300);
        ctrl_rdy = 1'b1;
        @(negedge clk);
        ctrl_rdy = 1'b0;
        drive_so(8'h96);
        $display("[TB] read 123 after reset rsp_valid=%0b rdata=%02h err=%0b", rq.rsp_valid, rq.rsp_rdata, rq.rsp_err);
        chk("post_rsp_valid_c27", rq.rsp_valid, 1);
        chk("post_rdata", rq.rsp_rdata, 8'h96);
        chk("post_err", rq.rsp_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
